// File: rtl/d_debounce.sv
// Two-flop synchroniser followed by a four-state debounce FSM that commits a level
// change only after STABLE_CYCLES consecutive enabled mismatching samples.
module d_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter logic        INIT          = 1'b0
) (
  input  logic clk,
  input  logic Rst,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } state_t;

  localparam state_t          RST_STATE = INIT ? IDLE_HI : IDLE_LO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      dout_q  <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Pulses default to 0 so they last exactly one edge and stay low while en=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE_LO: begin
          if (s2) begin
            if (STABLE_CYCLES == 1) begin
              state_d = IDLE_HI;
              dout_d  = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = CHK_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_HI: begin
          if (!s2) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HI;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!s2) begin
            if (STABLE_CYCLES == 1) begin
              state_d = IDLE_LO;
              dout_d  = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = CHK_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_LO: begin
          if (s2) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_LO;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RST_STATE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_d_debounce.sv
// Directed bench for d_debounce: three instances (N=4, N=2, N=1) checked against
// hand-derived {dout,rise,fall,busy} expectations queued per step.
module tb_d_debounce;

  logic clk = 1'b0;
  logic Rst;
  logic din4, en4, dout4, rise4, fall4, busy4;
  logic din2, en2, dout2, rise2, fall2, busy2;
  logic din1, en1, dout1, rise1, fall1, busy1;

  always #5 clk = ~clk;

  d_debounce #(.STABLE_CYCLES(4), .CNT_W(8), .INIT(1'b0)) u4 (
    .clk(clk), .Rst(Rst), .din(din4), .en(en4),
    .dout(dout4), .rise(rise4), .fall(fall4), .busy(busy4)
  );
  d_debounce #(.STABLE_CYCLES(2), .CNT_W(8), .INIT(1'b0)) u2 (
    .clk(clk), .Rst(Rst), .din(din2), .en(en2),
    .dout(dout2), .rise(rise2), .fall(fall2), .busy(busy2)
  );
  d_debounce #(.STABLE_CYCLES(1), .CNT_W(8), .INIT(1'b0)) u1 (
    .clk(clk), .Rst(Rst), .din(din1), .en(en1),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [3:0]  exp;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  function automatic logic [3:0] obs(int unsigned sel);
    case (sel)
      0:       return {dout4, rise4, fall4, busy4};
      1:       return {dout2, rise2, fall2, busy2};
      default: return {dout1, rise1, fall1, busy1};
    endcase
  endfunction

  task automatic push(string tag, int unsigned sel, logic [3:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [3:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      n_total++;
      assert (o === e.exp) n_passed++;
      else $error("FAIL %s: observed {dout,rise,fall,busy}=%b expected %b", e.tag, o, e.exp);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gl_exp [7];
    logic       gl_din [7];
    logic [3:0] en_exp [9];
    logic       en_pat [9];

    Rst = 1'b0;
    din4 = 1'b1; din2 = 1'b1; din1 = 1'b1;
    en4 = 1'b1; en2 = 1'b1; en1 = 1'b1;

    // Reset applied before any edge must already hold the outputs at INIT.
    #2;
    push("rst_async_u4", 0, 4'b0000);
    push("rst_async_u2", 1, 4'b0000);
    push("rst_async_u1", 2, 4'b0000);
    drain();
    for (int i = 0; i < 3; i++) begin
      push("rst_hold_u4", 0, 4'b0000);
      push("rst_hold_u2", 1, 4'b0000);
      push("rst_hold_u1", 2, 4'b0000);
      tick_check();
    end

    din4 = 1'b0; din2 = 1'b0; din1 = 1'b0;
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("settle_u4", 0, 4'b0000);
      push("settle_u1", 2, 4'b0000);
      tick_check();
    end

    // Glitch of 3 clocks: candidate aborts on the would-be commit edge.
    gl_din = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    gl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      din4 = gl_din[i];
      push("glitch_u4", 0, gl_exp[i]);
      tick_check();
    end

    din4 = 1'b1;
    gl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      push("rise_u4", 0, gl_exp[i]);
      tick_check();
    end

    din4 = 1'b0;
    gl_exp = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      push("fall_u4", 0, gl_exp[i]);
      tick_check();
    end

    din1 = 1'b1;
    gl_exp = '{4'b0000, 4'b0000, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      push("rise_n1", 2, gl_exp[i]);
      tick_check();
    end
    din1 = 1'b0;
    gl_exp = '{4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      push("fall_n1", 2, gl_exp[i]);
      tick_check();
    end
    din1 = 1'b1;
    for (int i = 0; i < 4; i++) tick_check();
    push("relevel_n1", 2, 4'b1000);
    drain();

    din2 = 1'b1;
    gl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b1100, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      push("rise_n2", 1, gl_exp[i]);
      tick_check();
    end

    din2 = 1'b0;
    en_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    en_exp = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
               4'b0010, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      en2 = en_pat[i];
      push("fall_en_n2", 1, en_exp[i]);
      tick_check();
    end
    en2 = 1'b1;

    din4 = 1'b1;
    gl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      push("prechk_u4", 0, gl_exp[i]);
      tick_check();
    end

    // Clock is high here; reset must clear outputs without waiting for an edge.
    Rst = 1'b0;
    #1;
    push("rst_mid_u4", 0, 4'b0000);
    push("rst_mid_u2", 1, 4'b0000);
    push("rst_mid_u1", 2, 4'b0000);
    drain();
    push("rst_mid_hold_u4", 0, 4'b0000);
    tick_check();
    Rst = 1'b1;

    gl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      push("restart_u4", 0, gl_exp[i]);
      tick_check();
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
